// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient loader: coefficient width,
// the filter's reset tap value and the loader state encoding.
package fir_pkg;

    localparam int COEF_W = 25;

    // Matches the tap value the filter itself comes out of reset with.
    localparam logic [COEF_W-1:0] COEF_DEFAULT = 25'h0000080;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } load_state_e;

endpackage

// File: rtl/fir_coef_loader_if.sv
// CPU-side buffer access plus the filter configuration stream of the loader,
// bundled so the loader and its host/filter see one connection.
interface fir_coef_loader_if #(
    parameter int MAX_LEN = 64,
    parameter int COEF_W  = fir_pkg::COEF_W
);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [COEF_W-1:0] wr_data;
    logic [AW-1:0]     rd_addr;
    logic [COEF_W-1:0] rd_data;
    logic              start;
    logic              abort;
    logic [31:0]       filt_len;
    logic [COEF_W-1:0] cfg_din;
    logic              cfg_ce;
    logic              busy;
    logic              done;
    logic              err;

    // Handshake: start is a single-cycle request with no ready; it is taken
    // only while busy is low. cfg_ce is a valid with no back-pressure: the
    // filter accepts exactly one cfg_din word on every cycle cfg_ce is high.
    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, start, abort, filt_len,
        input  rd_data, cfg_din, cfg_ce, busy, done, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, start, abort, filt_len,
        output rd_data, cfg_din, cfg_ce, busy, done, err
    );

endinterface

// File: rtl/fir_coef_buf.sv
// Coefficient register file: one write port, two combinational read ports,
// asynchronously reset to the filter's default tap value.
module fir_coef_buf #(
    parameter int MAX_LEN = 64,
    parameter int COEF_W  = fir_pkg::COEF_W,
    parameter logic [COEF_W-1:0] RST_VAL = COEF_W'(fir_pkg::COEF_DEFAULT),
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [COEF_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_a_i,
    output logic [COEF_W-1:0] rdata_a_o,
    input  logic [AW-1:0]     raddr_b_i,
    output logic [COEF_W-1:0] rdata_b_o
);

    logic [COEF_W-1:0] mem_q [MAX_LEN];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                mem_q[i] <= RST_VAL;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/fir_coef_loader.sv
// Streams buffered coefficients into the filter's shift chain, highest tap
// first, so that h[0] is the last word shifted in and ends up on tap 1.
module fir_coef_loader
    import fir_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int COEF_W  = fir_pkg::COEF_W
) (
    input  logic             clk,
    input  logic             reset,
    fir_coef_loader_if.slave bus,
    output load_state_e      dbg_state_o
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    load_state_e       state_q;
    logic [AW-1:0]     cnt_q;
    logic [AW-1:0]     cnt_d;
    logic              cfg_ce_q;
    logic [COEF_W-1:0] cfg_din_q;
    logic              done_q;
    logic              err_q;

    logic              len_ok;
    logic              start_go;
    logic              buf_we;
    logic [AW-1:0]     first_idx;
    logic [AW-1:0]     ld_addr;
    logic [COEF_W-1:0] ld_data;
    logic [COEF_W-1:0] first_word;

    assign len_ok    = (bus.filt_len != 32'd0) && (bus.filt_len <= 32'(MAX_LEN));
    assign start_go  = (state_q == IDLE) && bus.start && !bus.abort;
    assign buf_we    = (state_q == IDLE) && bus.wr_en;
    assign first_idx = AW'(bus.filt_len - 32'd1);
    assign cnt_d     = cnt_q - AW'(1);
    assign ld_addr   = (state_q == IDLE) ? first_idx : cnt_d;

    // A write landing on the first word in the start cycle is forwarded,
    // since the buffer itself only updates at that same edge.
    assign first_word = (buf_we && (bus.wr_addr == first_idx)) ? bus.wr_data : ld_data;

    fir_coef_buf #(
        .MAX_LEN (MAX_LEN),
        .COEF_W  (COEF_W)
    ) u_buf (
        .clk_i     (clk),
        .rst_ni    (reset),
        .we_i      (buf_we),
        .waddr_i   (bus.wr_addr),
        .wdata_i   (bus.wr_data),
        .raddr_a_i (ld_addr),
        .rdata_a_o (ld_data),
        .raddr_b_i (bus.rd_addr),
        .rdata_b_o (bus.rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cfg_ce_q  <= 1'b0;
            cfg_din_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    cfg_ce_q <= 1'b0;
                    if (start_go) begin
                        if (len_ok) begin
                            state_q   <= LOAD;
                            cnt_q     <= first_idx;
                            cfg_ce_q  <= 1'b1;
                            cfg_din_q <= first_word;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    // cnt_q is the index of the word currently on cfg_din.
                    if (bus.abort || (cnt_q == '0)) begin
                        state_q  <= IDLE;
                        cfg_ce_q <= 1'b0;
                        done_q   <= !bus.abort;
                    end else begin
                        cnt_q     <= cnt_d;
                        cfg_ce_q  <= 1'b1;
                        cfg_din_q <= ld_data;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cfg_ce   = cfg_ce_q;
    assign bus.cfg_din  = cfg_din_q;
    assign bus.busy     = (state_q == LOAD);
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign dbg_state_o  = state_q;

endmodule
